// File: rtl/wb_regfile.sv
// Writeback select plus 16 x 16-bit register file with a dedicated R15 write port
// and write-before-read bypass on both combinational read ports.
module wb_regfile #(
    parameter int DATA_W = 16,
    parameter int NREGS  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     regWrite,
    input  logic                     R15Write,
    input  logic                     MemtoReg,
    input  logic                     loadByte,
    input  logic [DATA_W-1:0]        readData,
    input  logic [DATA_W-1:0]        res,
    input  logic [DATA_W-1:0]        R15_data,
    input  logic [$clog2(NREGS)-1:0] regDes,
    input  logic [$clog2(NREGS)-1:0] rdAddr1,
    input  logic [$clog2(NREGS)-1:0] rdAddr2,
    output logic [DATA_W-1:0]        rdData1,
    output logic [DATA_W-1:0]        rdData2,
    output logic [DATA_W-1:0]        wbData
);

    localparam int AW = $clog2(NREGS);
    localparam logic [AW-1:0] R15_ADDR = AW'(NREGS - 1);

    logic [DATA_W-1:0] regFile_r [NREGS];
    logic [DATA_W-1:0] wbData_s;
    logic [DATA_W-1:0] rdData1_s;
    logic [DATA_W-1:0] rdData2_s;

    // Secondary-port forwarding outranks the primary port, mirroring the write priority.
    function automatic logic [DATA_W-1:0] bypassRead(
        input logic [AW-1:0]     addr,
        input logic              wrEn,
        input logic [AW-1:0]     wrAddr,
        input logic [DATA_W-1:0] wrData,
        input logic              r15En,
        input logic [DATA_W-1:0] r15Data,
        input logic [DATA_W-1:0] stored
    );
        logic [DATA_W-1:0] value;
        if (r15En && (addr == R15_ADDR)) begin
            value = r15Data;
        end else if (wrEn && (addr == wrAddr)) begin
            value = wrData;
        end else begin
            value = stored;
        end
        return value;
    endfunction

    // Writeback value selection: ALU result, full memory word or zero-extended byte.
    always_comb begin
        wbData_s = res;
        case ({MemtoReg, loadByte})
            2'b00, 2'b01: wbData_s = res;
            2'b10:        wbData_s = readData;
            2'b11:        wbData_s = {{(DATA_W-8){1'b0}}, readData[7:0]};
            default:      wbData_s = res;
        endcase
    end

    // Read ports with same-cycle bypass; active regardless of reset.
    always_comb begin
        rdData1_s = bypassRead(rdAddr1, regWrite, regDes, wbData_s,
                               R15Write, R15_data, regFile_r[rdAddr1]);
        rdData2_s = bypassRead(rdAddr2, regWrite, regDes, wbData_s,
                               R15Write, R15_data, regFile_r[rdAddr2]);
    end

    // Register commit; the R15 port is written last so it wins a collision on R15.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regFile_r[i] <= {DATA_W{1'b0}};
            end
        end else begin
            if (regWrite) begin
                regFile_r[regDes] <= wbData_s;
            end
            if (R15Write) begin
                regFile_r[R15_ADDR] <= R15_data;
            end
        end
    end

    assign wbData  = wbData_s;
    assign rdData1 = rdData1_s;
    assign rdData2 = rdData2_s;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: stimulus queues expected outputs, a negedge
// monitor pops and compares them against the DUT.
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic        regWrite;
    logic        R15Write;
    logic        MemtoReg;
    logic        loadByte;
    logic [15:0] readData;
    logic [15:0] res;
    logic [15:0] R15_data;
    logic [3:0]  regDes;
    logic [3:0]  rdAddr1;
    logic [3:0]  rdAddr2;
    logic [15:0] rdData1;
    logic [15:0] rdData2;
    logic [15:0] wbData;

    typedef struct {
        string       name;
        int          port;
        logic [15:0] exp;
    } expItem_t;

    expItem_t expQ[$];
    int checks   = 0;
    int failures = 0;

    wb_regfile #(.DATA_W(16), .NREGS(16)) dut (
        .clk(clk), .rst(rst), .regWrite(regWrite), .R15Write(R15Write),
        .MemtoReg(MemtoReg), .loadByte(loadByte), .readData(readData),
        .res(res), .R15_data(R15_data), .regDes(regDes),
        .rdAddr1(rdAddr1), .rdAddr2(rdAddr2),
        .rdData1(rdData1), .rdData2(rdData2), .wbData(wbData)
    );

    always #5 clk = ~clk;

    // Monitor: compare every queued expectation against the settled outputs.
    always @(negedge clk) begin
        while (expQ.size() > 0) begin
            expItem_t it;
            logic [15:0] act;
            it = expQ.pop_front();
            case (it.port)
                0:       act = rdData1;
                1:       act = rdData2;
                default: act = wbData;
            endcase
            checks++;
            if (act !== it.exp) begin
                failures++;
                $display("FAIL %s: got %h, expected %h", it.name, act, it.exp);
            end
        end
    end

    task automatic expect_out(input string n, input int p, input logic [15:0] v);
        expItem_t it;
        it.name = n;
        it.port = p;
        it.exp  = v;
        expQ.push_back(it);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        regWrite = 1'b0;
        R15Write = 1'b0;
        MemtoReg = 1'b0;
        loadByte = 1'b0;
    endtask

    initial begin
        int waitCycles;
        rst = 1'b1; idle();
        readData = 16'h0000; res = 16'h0000; R15_data = 16'h0000;
        regDes = 4'd0; rdAddr1 = 4'd0; rdAddr2 = 4'd0;
        tick();

        // Reset with a write pending: bypass visible, write dropped
        rst = 1'b1; regWrite = 1'b1; regDes = 4'd4; res = 16'hBEEF; rdAddr1 = 4'd4;
        expect_out("bypass_in_reset", 0, 16'hBEEF);
        tick();
        rst = 1'b0; idle();
        for (int i = 0; i < 16; i++) begin
            rdAddr1 = 4'(i);
            rdAddr2 = 4'(15 - i);
            expect_out($sformatf("reset_rd1_r%0d", i), 0, 16'h0000);
            expect_out($sformatf("reset_rd2_r%0d", 15 - i), 1, 16'h0000);
            tick();
        end

        // Writeback mux
        readData = 16'h12F0; res = 16'h0100; regDes = 4'd3; rdAddr1 = 4'd3;
        regWrite = 1'b1; MemtoReg = 1'b0; loadByte = 1'b1;
        expect_out("wb_res_loadbyte_ignored", 2, 16'h0100);
        tick();
        regWrite = 1'b1; MemtoReg = 1'b0; loadByte = 1'b0;
        expect_out("wb_res", 2, 16'h0100);
        tick();
        idle();
        expect_out("r3_res", 0, 16'h0100);
        tick();
        regWrite = 1'b1; MemtoReg = 1'b1; loadByte = 1'b0;
        expect_out("wb_word", 2, 16'h12F0);
        tick();
        idle();
        expect_out("r3_word", 0, 16'h12F0);
        tick();
        regWrite = 1'b1; MemtoReg = 1'b1; loadByte = 1'b1;
        expect_out("wb_byte", 2, 16'h00F0);
        tick();
        idle();
        expect_out("r3_byte", 0, 16'h00F0);
        tick();

        // Dual write
        regWrite = 1'b1; regDes = 4'd2; res = 16'h0007;
        R15Write = 1'b1; R15_data = 16'h00A5;
        tick();
        idle(); rdAddr1 = 4'd2; rdAddr2 = 4'd15;
        expect_out("dual_r2", 0, 16'h0007);
        expect_out("dual_r15", 1, 16'h00A5);
        tick();

        // Collision on R15
        regWrite = 1'b1; regDes = 4'd15; res = 16'h1111;
        R15Write = 1'b1; R15_data = 16'h2222; rdAddr1 = 4'd15; rdAddr2 = 4'd15;
        expect_out("collide_bypass_rd2", 1, 16'h2222);
        expect_out("collide_bypass_rd1", 0, 16'h2222);
        tick();
        idle();
        expect_out("collide_r15", 0, 16'h2222);
        tick();

        // Bypass
        regWrite = 1'b1; regDes = 4'd5; res = 16'h0001;
        tick();
        regWrite = 1'b1; regDes = 4'd6; res = 16'h0066;
        tick();
        idle(); regDes = 4'd5; res = 16'h0055; rdAddr1 = 4'd5; rdAddr2 = 4'd6;
        expect_out("nobypass_r5", 0, 16'h0001);
        tick();
        regWrite = 1'b1;
        expect_out("bypass_r5", 0, 16'h0055);
        expect_out("bypass_r6_old", 1, 16'h0066);
        tick();
        idle();
        expect_out("r5_stored", 0, 16'h0055);
        tick();

        // Reset mid-stream
        regWrite = 1'b1; regDes = 4'd7; res = 16'h0100;
        tick();
        idle(); rdAddr1 = 4'd7;
        expect_out("r7_written", 0, 16'h0100);
        tick();
        rst = 1'b1; regWrite = 1'b1; regDes = 4'd8; res = 16'h0200;
        tick();
        rst = 1'b0; idle(); rdAddr1 = 4'd7; rdAddr2 = 4'd8;
        expect_out("midrst_r7", 0, 16'h0000);
        expect_out("midrst_r8", 1, 16'h0000);
        tick();
        rdAddr1 = 4'd15; rdAddr2 = 4'd5;
        expect_out("midrst_r15", 0, 16'h0000);
        expect_out("midrst_r5", 1, 16'h0000);
        tick();

        waitCycles = 0;
        while (expQ.size() > 0 && waitCycles < 10) begin
            tick();
            waitCycles++;
        end
        if (expQ.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: %0d pending, expected 0", expQ.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Writeback stage and register file of the 16-bit pipelined processor. It consumes the MEM/WB pipeline buffer outputs, selects the writeback value (ALU result, full memory word, or zero-extended memory byte), and commits it to a 16 x 16-bit register file on the clock edge. A dedicated second write port updates R15 (high half of multiply / remainder of divide). Two combinational read ports serve the decode stage, with same-cycle write-to-read bypass so the decode stage never reads a stale value.

## Interface
Parameters:
- DATA_W, 16, register and datapath width
- NREGS, 16, number of registers (address width = 4)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- regWrite  in  1  write wbData into register regDes
- R15Write  in  1  write R15_data into R15
- MemtoReg  in  1  1 = writeback from memory data, 0 = from res
- loadByte  in  1  when MemtoReg=1: use readData[7:0] zero-extended
- readData  in  16  memory read data from MEM/WB
- res  in  16  ALU result from MEM/WB
- R15_data  in  16  secondary result (MUL high / DIV remainder) from MEM/WB
- regDes  in  4  destination register number
- rdAddr1  in  4  read port 1 address
- rdAddr2  in  4  read port 2 address
- rdData1  out  16  read port 1 data (combinational, bypassed)
- rdData2  out  16  read port 2 data (combinational, bypassed)
- wbData  out  16  selected writeback value (combinational, also feeds the forwarding unit)

## Operation
- Writeback select:
  - MemtoReg=0 -> wbData = res
  - MemtoReg=1, loadByte=0 -> wbData = readData
  - MemtoReg=1, loadByte=1 -> wbData = {8'h00, readData[7:0]}
  - loadByte is ignored when MemtoReg=0.
- Register writes at the rising edge when rst=0:
  - If regWrite=1, then regs[regDes] <= wbData.
  - If R15Write=1, then regs[15] <= R15_data.
- Both write ports may fire in the same cycle. When regDes=15 and both are set, R15Write wins and regs[15] <= R15_data.
- All 16 registers, including R0, are ordinary writable registers.
- Read ports, resolved in priority order:
  1. rdAddr=15 and R15Write=1 -> R15_data.
  2. rdAddr=regDes and regWrite=1 -> wbData.
  3. Otherwise regs[rdAddr].
- The bypass is active even while rst=1. The registers stay unwritten during reset, but the bypassed value is presented.
- Reset (rst=1 at the rising edge): every register is cleared to 16'h0000, and all writes in that cycle are suppressed.
  - Reset asserted mid-sequence discards any writeback in flight that cycle.
  - After reset, rdData1 and rdData2 read 0 for any non-bypassed address.
  - wbData has no reset value; it is purely combinational from its inputs.

## Timing
- Write latency: 1 cycle. A value presented at edge N is visible from regs (non-bypassed) after edge N.
- Read latency: 0 cycles (combinational). Through the bypass, a write and a read of the same register in one cycle return the new value: write-before-read.
- No handshakes. The inputs are registered MEM/WB outputs, and the block accepts one writeback per cycle unconditionally.
- No combinational path from rdAddr to wbData.

## Test plan
- **Reset:** rst=1 for one edge with regWrite=1, regDes=4, res=16'hBEEF. Then release rst. Required: rdData1 at rdAddr1=4 reads 16'h0000, and all 16 registers read 0.
- **Writeback mux:** readData=16'h12F0, res=16'h0100, regDes=3, regWrite=1, applied across three cycles:
  - MemtoReg=0 -> R3 = 16'h0100
  - MemtoReg=1, loadByte=0 -> R3 = 16'h12F0
  - MemtoReg=1, loadByte=1 -> R3 = 16'h00F0
- **Dual write:** regWrite=1, regDes=2, res=16'h0007, R15Write=1, R15_data=16'h00A5 in the same cycle. Required: R2 = 16'h0007 and R15 = 16'h00A5 after the edge.
- **Collision on R15:** regWrite=1, regDes=15, res=16'h1111, R15Write=1, R15_data=16'h2222. Required:
  - Before the edge, rdData2 at rdAddr2=15 = 16'h2222.
  - After the edge, R15 = 16'h2222.
- **Bypass:** R5 holds 16'h0001. In one cycle drive regWrite=1, regDes=5, res=16'h0055 with rdAddr1=5 and rdAddr2=6. Required:
  - rdData1 = 16'h0055 in the same cycle.
  - rdData2 = old R6.
  - With regWrite=0, rdData1 still returns the stored R5.
- **Reset mid-stream:** write R7=16'h0100, then assert rst=1 in the cycle carrying regWrite=1, regDes=8, res=16'h0200. Required: after the edge, R7=0 and R8=0.
